mem_bus_mux: RTL and testbench

Parametrised N-slave interconnect for the picorv32 native memory bus. It sits between the core and its RAM, UART and other memory-mapped peripherals. It decodes `mem_addr[31:28]` against a per-slave region mask and sequences one transaction at a time through a registered handshake. It also terminates unmapped or hung accesses with a fixed read value and an error pulse, so a bad pointer cannot stall the core.

---
 rtl/mem_bus_mux.sv | 142 ++++++++++++++
 tb/tb_mem_bus_mux.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_mux.sv
// Region-decoded N-slave interconnect for the picorv32 native memory bus.
// Define MEM_BUS_TIMEOUT_EN to abort slave accesses that stall for TIMEOUT cycles.
module mem_bus_mux #(
  parameter int unsigned         N_SLV         = 2,
  parameter logic [N_SLV*16-1:0] SLV_REGIONS   = {16'h0301, 16'h0020},
  parameter logic [31:0]         DEFAULT_RDATA = 32'hDEADBEEF,
  parameter int unsigned         TIMEOUT       = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_rdata,
  output logic [N_SLV-1:0]      s_valid,
  input  logic [N_SLV-1:0]      s_ready,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic [N_SLV*32-1:0]   s_rdata,
  output logic                  bus_err,
  output logic [31:0]           err_addr
);

  localparam int unsigned SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, hit_idx;
  logic             hit;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic [31:0]      rdata_d, err_addr_d;
  logic             err_d;
  logic             timed_out;

  assign s_addr    = mem_addr;
  assign s_wdata   = mem_wdata;
  assign s_wstrb   = mem_wstrb;
  assign mem_ready = (state_q == RESP);

  // Descending scan so the lowest-index matching slave is the last writer.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (SLV_REGIONS[i*16 + int'(mem_addr[31:28])]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    s_valid   = '0;
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (SEL_W'(i) == sel_q) begin
        s_valid[i] = (state_q == BUSY);
        sel_ready  = s_ready[i];
        sel_rdata  = s_rdata[i*32 +: 32];
      end
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                cnt_q <= '0;
    else if (state_q != BUSY)  cnt_q <= '0;
    else                       cnt_q <= cnt_q + 1'b1;
  end

  // Abort in the BUSY cycle whose increment would bring the count to TIMEOUT.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign timed_out      = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    // NOTE: every output of this block is assigned a default first so no path leaves it holding a value, which would infer a latch.
    state_d    = state_q;
    sel_d      = sel_q;
    rdata_d    = mem_rdata;
    err_d      = 1'b0;
    err_addr_d = err_addr;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (hit) begin
            sel_d   = hit_idx;
            state_d = BUSY;
          end else begin
            rdata_d    = DEFAULT_RDATA;
            err_d      = 1'b1;
            err_addr_d = mem_addr;
            state_d    = RESP;
          end
        end
      end
      BUSY: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          state_d = RESP;
        end else if (timed_out) begin
          rdata_d    = DEFAULT_RDATA;
          err_d      = 1'b1;
          err_addr_d = mem_addr;
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mem_rdata <= rdata_d;
      bus_err   <= err_d;
      err_addr  <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_mux.sv
// Self-checking bench for mem_bus_mux: latency-programmable slave stubs plus a response scoreboard.
// Timeout scenarios run when MEM_BUS_TIMEOUT_EN is defined; otherwise a long-wait slave is checked.
module tb_mem_bus_mux;

  localparam int          N   = 2;
  localparam logic [31:0] DEF = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_valid = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [N-1:0]  s_valid;
  logic [N-1:0]  s_ready;
  logic [31:0]   s_addr, s_wdata;
  logic [3:0]    s_wstrb;
  logic [N*32-1:0] s_rdata;
  logic          bus_err;
  logic [31:0]   err_addr;

  int errors = 0;
  int checks = 0;

  mem_bus_mux #(
    .N_SLV        (N),
    .SLV_REGIONS  ({16'h0220, 16'h0301}),
    .DEFAULT_RDATA(DEF),
    .TIMEOUT      (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .bus_err  (bus_err),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  // Slave stubs: ready once s_valid has been high for lat[i] earlier cycles; data = base ^ address.
  int          lat [N]  = '{0, 0};
  logic [31:0] base [N] = '{32'h0, 32'h0};
  int          wait_cnt [N] = '{0, 0};
  int          cyc_now = 0;
  int          ready_count = 0;

  always @(posedge clk) begin
    cyc_now <= cyc_now + 1;
    for (int i = 0; i < N; i++) wait_cnt[i] <= s_valid[i] ? wait_cnt[i] + 1 : 0;
  end

  always @* begin
    for (int i = 0; i < N; i++) begin
      s_ready[i]          = s_valid[i] && (wait_cnt[i] >= lat[i]);
      s_rdata[i*32 +: 32] = base[i] ^ s_addr;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (mem_ready === 1'b1) begin
      ready_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ready: mem_ready seen at cycle %0d with no pending transaction", cyc_now);
      end else begin
        e = sb.pop_front();
        if ((e.chk_rdata && mem_rdata !== e.rdata) || bus_err !== e.err) begin
          errors++;
          $display("FAIL sb_resp: got rdata=%h bus_err=%b, required rdata=%h bus_err=%b (rdata checked=%0d)",
                   mem_rdata, bus_err, e.rdata, e.err, e.chk_rdata);
        end
      end
    end
  end

  int          obs_lat;
  int          obs_sv_cyc [N];
  int          obs_err_cyc;
  logic [N-1:0] obs_sv_mask;
  logic [31:0] obs_saddr, obs_swdata, obs_err_addr;
  logic [3:0]  obs_swstrb;
  int          t_sv, t_ready;

  // Drives one request from the current negedge (cycle 1) and observes until mem_ready.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] exp_rdata, input bit chk, input bit exp_err);
    int cyc;
    bit done;
    sb.push_back(exp_t'{exp_rdata, chk, exp_err});
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    for (int i = 0; i < N; i++) obs_sv_cyc[i] = 0;
    obs_err_cyc = 0;
    obs_sv_mask = '0;
    obs_lat     = -1;
    t_sv        = -1;
    t_ready     = -1;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (s_valid != '0 && t_sv < 0) begin
        t_sv       = cyc_now;
        obs_saddr  = s_addr;
        obs_swdata = s_wdata;
        obs_swstrb = s_wstrb;
      end
      for (int i = 0; i < N; i++) if (s_valid[i]) obs_sv_cyc[i]++;
      obs_sv_mask |= s_valid;
      if (bus_err) obs_err_cyc++;
      if (mem_ready) begin
        done         = 1'b1;
        obs_lat      = cyc;
        t_ready      = cyc_now;
        obs_err_addr = err_addr;
        mem_valid    = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: addr=%h got no mem_ready within 64 cycles, required one", addr);
      mem_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready: got %b required 0", mem_ready); end
    if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_mem_rdata: got %h required 00000000", mem_rdata); end
    if (s_valid !== '0) begin errors++; $display("FAIL rst_s_valid: got %b required 00", s_valid); end
    if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b required 0", bus_err); end
    if (err_addr !== 32'h0) begin errors++; $display("FAIL rst_err_addr: got %h required 00000000", err_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_read();
    lat[0]  = 2;
    base[0] = 32'h12345678 ^ 32'h00000010;
    run_txn(32'h00000010, 32'h0, 4'h0, 32'h12345678, 1'b1, 1'b0);
    checks += 5;
    if (obs_sv_cyc[0] != 3) begin errors++; $display("FAIL ram_sv0_cycles: got %0d required 3", obs_sv_cyc[0]); end
    if (obs_sv_cyc[1] != 0) begin errors++; $display("FAIL ram_sv1_cycles: got %0d required 0", obs_sv_cyc[1]); end
    if (obs_lat != 5) begin errors++; $display("FAIL ram_latency: got %0d required 5", obs_lat); end
    if (obs_err_cyc != 0) begin errors++; $display("FAIL ram_bus_err: got %0d pulses required 0", obs_err_cyc); end
    if (obs_saddr !== 32'h00000010) begin errors++; $display("FAIL ram_s_addr: got %h required 00000010", obs_saddr); end
    @(negedge clk);
  endtask

  task automatic test_write();
    int rc;
    lat[1] = 0;
    rc = ready_count;
    run_txn(32'h50000004, 32'h00000041, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checks += 5;
    if (obs_sv_mask !== 2'b10) begin errors++; $display("FAIL wr_sv_mask: got %b required 10", obs_sv_mask); end
    if (obs_swdata !== 32'h41) begin errors++; $display("FAIL wr_s_wdata: got %h required 00000041", obs_swdata); end
    if (obs_swstrb !== 4'hF) begin errors++; $display("FAIL wr_s_wstrb: got %h required f", obs_swstrb); end
    if (obs_lat != 3) begin errors++; $display("FAIL wr_latency: got %0d required 3", obs_lat); end
    if (ready_count - rc != 1) begin errors++; $display("FAIL wr_ready_pulses: got %0d required 1", ready_count - rc); end
  endtask

  task automatic test_unmapped();
    run_txn(32'h30000000, 32'h0, 4'h0, DEF, 1'b1, 1'b1);
    checks += 4;
    if (obs_sv_mask !== 2'b00) begin errors++; $display("FAIL unm_sv_mask: got %b required 00", obs_sv_mask); end
    if (obs_lat != 2) begin errors++; $display("FAIL unm_latency: got %0d required 2", obs_lat); end
    if (obs_err_cyc != 1) begin errors++; $display("FAIL unm_err_pulses: got %0d required 1", obs_err_cyc); end
    if (obs_err_addr !== 32'h30000000) begin errors++; $display("FAIL unm_err_addr: got %h required 30000000", obs_err_addr); end
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL unm_err_drop: got %b required 0", bus_err); end
  endtask

  task automatic test_err_hold();
    lat[0]  = 1;
    base[0] = 32'h0BADF00D;
    run_txn(32'h80000004, 32'h0, 4'h0, 32'h0BADF00D ^ 32'h80000004, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks += 2;
    if (err_addr !== 32'h30000000) begin errors++; $display("FAIL hold_err_addr: got %h required 30000000", err_addr); end
    if (mem_rdata !== (32'h0BADF00D ^ 32'h80000004)) begin
      errors++; $display("FAIL hold_mem_rdata: got %h required %h", mem_rdata, 32'h0BADF00D ^ 32'h80000004);
    end
  endtask

  task automatic test_overlap();
    lat[0] = 0;
    lat[1] = 0;
    base[0] = 32'h11110000;
    base[1] = 32'h22220000;
    run_txn(32'h90000010, 32'h0, 4'h0, 32'h11110000 ^ 32'h90000010, 1'b1, 1'b0);
    checks++;
    if (obs_sv_mask !== 2'b01) begin errors++; $display("FAIL overlap_sv_mask: got %b required 01", obs_sv_mask); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int first_ready;
    lat[0]  = 0;
    base[0] = 32'hA5A50000;
    run_txn(32'h80000000, 32'h0, 4'h0, 32'hA5A50000 ^ 32'h80000000, 1'b1, 1'b0);
    first_ready = t_ready;
    run_txn(32'h90000000, 32'h0, 4'h0, 32'hA5A50000 ^ 32'h90000000, 1'b1, 1'b0);
    checks += 2;
    if (t_sv - first_ready != 2) begin errors++; $display("FAIL b2b_gap: got %0d cycles required 2", t_sv - first_ready); end
    if (obs_sv_cyc[0] != 1) begin errors++; $display("FAIL b2b_sv0_cycles: got %0d required 1", obs_sv_cyc[0]); end
    @(negedge clk);
  endtask

`ifdef MEM_BUS_TIMEOUT_EN
  task automatic test_timeout();
    lat[1]  = 255;
    base[1] = 32'h5A5A0000;
    run_txn(32'h50000008, 32'h0, 4'h0, DEF, 1'b1, 1'b1);
    checks += 4;
    if (obs_sv_cyc[1] != 8) begin errors++; $display("FAIL to_sv1_cycles: got %0d required 8", obs_sv_cyc[1]); end
    if (obs_err_cyc != 1) begin errors++; $display("FAIL to_err_pulses: got %0d required 1", obs_err_cyc); end
    if (obs_err_addr !== 32'h50000008) begin errors++; $display("FAIL to_err_addr: got %h required 50000008", obs_err_addr); end
    if (obs_lat != 10) begin errors++; $display("FAIL to_latency: got %0d required 10", obs_lat); end
    @(negedge clk);
    lat[1] = 7;
    run_txn(32'h5000000C, 32'h0, 4'h0, 32'h5A5A0000 ^ 32'h5000000C, 1'b1, 1'b0);
    checks += 3;
    if (obs_sv_cyc[1] != 8) begin errors++; $display("FAIL to_edge_sv1_cycles: got %0d required 8", obs_sv_cyc[1]); end
    if (obs_err_cyc != 0) begin errors++; $display("FAIL to_edge_err: got %0d pulses required 0", obs_err_cyc); end
    if (err_addr !== 32'h50000008) begin errors++; $display("FAIL to_edge_err_addr: got %h required 50000008", err_addr); end
    @(negedge clk);
  endtask
`else
  task automatic test_long_wait();
    lat[1]  = 40;
    base[1] = 32'h5A5A0000;
    run_txn(32'h50000008, 32'h0, 4'h0, 32'h5A5A0000 ^ 32'h50000008, 1'b1, 1'b0);
    checks += 2;
    if (obs_sv_cyc[1] != 41) begin errors++; $display("FAIL long_sv1_cycles: got %0d required 41", obs_sv_cyc[1]); end
    if (obs_err_cyc != 0) begin errors++; $display("FAIL long_err: got %0d pulses required 0", obs_err_cyc); end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    int rc;
    int n;
    lat[1]    = 255;
    mem_addr  = 32'h50000000;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    n = 0;
    while (s_valid[1] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_valid[1] !== 1'b1) begin errors++; $display("FAIL mid_busy: got s_valid=%b required 10 before reset", s_valid); end
    rc = ready_count;
    rst_n     = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (s_valid !== 2'b00) begin errors++; $display("FAIL mid_s_valid: got %b required 00", s_valid); end
    if (mem_ready !== 1'b0) begin errors++; $display("FAIL mid_mem_ready: got %b required 0", mem_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ready_count != rc) begin errors++; $display("FAIL mid_no_ready: got %0d pulses required 0", ready_count - rc); end
    lat[0]  = 1;
    base[0] = 32'hC0DE0000;
    run_txn(32'h00000020, 32'h0, 4'h0, 32'hC0DE0000 ^ 32'h00000020, 1'b1, 1'b0);
    checks++;
    if (obs_lat != 4) begin errors++; $display("FAIL mid_fresh_latency: got %0d required 4", obs_lat); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_write();
    test_unmapped();
    test_err_hold();
    test_overlap();
    test_back_to_back();
`ifdef MEM_BUS_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending responses required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
